// File: rtl/fft_tone_detector_if.sv
// fft_tone_detector_if: bundles the FFT output stream and the control-FSM handshake
// for fft_tone_detector.
//   TDenable  control FSM -> detector, level, high = detect
//   i_ce      FFT data-advance strobe; o_result/o_sync are valid only while it is high
//   o_result  {re[IW-1:0], im[IW-1:0]}, two's complement
//   o_sync    high with i_ce on bin 0 of each FFT output frame
//   done      detector -> control FSM, result-ready level
//   Tone      detected bin index, zero-extended; 16'hFFFF = no tone
// Modports: master = stream/control source, slave = detector.
interface fft_tone_detector_if #(
    parameter int unsigned IW = 8
);
    logic              TDenable;
    logic              i_ce;
    logic [2*IW-1:0]   o_result;
    logic              o_sync;
    logic              done;
    logic [15:0]       Tone;

    modport master (
        output TDenable, i_ce, o_result, o_sync,
        input  done, Tone
    );

    modport slave (
        input  TDenable, i_ce, o_result, o_sync,
        output done, Tone
    );
endinterface

// File: rtl/fft_tone_detector.sv
// fft_tone_detector: scans the positive half of each FFT output frame for the bin with
// the largest L1 magnitude (|re| + |im|) and reports it on Tone, raising done.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    fft_tone_detector_if.slave (TDenable, i_ce, o_result, o_sync in; done, Tone out)
// Optional feature: define TD_CONFIRM_EN to require CONFIRM_N consecutive frames with the
// same candidate before done/Tone are updated.
module fft_tone_detector #(
    parameter int unsigned FFT_LEN   = 64,
    parameter int unsigned IW        = 8,
    parameter int unsigned MIN_BIN   = 1,
    parameter int unsigned THRESH    = 16,
    parameter int unsigned CONFIRM_N = 2
) (
    input  logic              clk,
    input  logic              reset,
    fft_tone_detector_if.slave bus
);

    localparam int unsigned    HALF     = FFT_LEN / 2;
    localparam int unsigned    CW       = (FFT_LEN > 2) ? $clog2(FFT_LEN) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(HALF - 1);

    typedef enum logic [1:0] {StIdle, StScan, StReport, StHold} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW:0]     peak_q, peak_d;
    logic [CW-1:0]   peak_idx_q, peak_idx_d;
    logic            done_q, done_d;
    logic [15:0]     tone_q, tone_d;

    // Absolute value one bit wider than the input so that -2^(IW-1) does not wrap.
    function automatic logic [IW:0] abs_ext(input logic [IW-1:0] v);
        logic [IW:0] w;
        w = {v[IW-1], v};
        return w[IW] ? ((~w) + (IW+1)'(1)) : w;
    endfunction

    logic [IW-1:0]  re_bits, im_bits;
    logic [IW:0]    mag;
    logic           sync_smp;
    logic [CW-1:0]  cur_idx;
    logic [IW:0]    base_peak;
    logic [CW-1:0]  base_idx;
    logic           better;
    logic [15:0]    cand;
    logic           take;

    assign re_bits = bus.o_result[2*IW-1:IW];
    assign im_bits = bus.o_result[IW-1:0];
    // |re| and |im| are each <= 2^(IW-1), so the sum fits in IW+1 bits.
    assign mag     = abs_ext(re_bits) + abs_ext(im_bits);

    // A sync sample always restarts the frame: it is bin 0 and sees an empty peak.
    assign sync_smp  = bus.i_ce && bus.o_sync;
    assign cur_idx   = sync_smp ? '0 : count_q;
    assign base_peak = sync_smp ? '0 : peak_q;
    assign base_idx  = sync_smp ? '0 : peak_idx_q;
    // Strict compare keeps the lowest index on ties.
    assign better    = (32'(cur_idx) >= MIN_BIN) && (mag > base_peak);

    assign cand = (32'(peak_q) >= THRESH) ? 16'(peak_idx_q) : 16'hFFFF;

`ifdef TD_CONFIRM_EN
    logic [15:0] prev_q, prev_d;
    logic [15:0] match_q, match_d;
    logic [15:0] new_match;

    // match_q == 0 means there is no previous candidate to compare against.
    assign new_match = ((match_q != 16'd0) && (cand == prev_q)) ? (match_q + 16'd1) : 16'd1;
`else
    logic unused_confirm;
    assign unused_confirm = ^CONFIRM_N;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        done_d     = done_q;
        tone_d     = tone_q;
        take       = 1'b0;
`ifdef TD_CONFIRM_EN
        prev_d     = prev_q;
        match_d    = match_q;
`endif

        case (state_q)
            StIdle: begin
                if (bus.TDenable && sync_smp) begin
                    take = 1'b1;
                end
            end
            StScan: begin
                if (!bus.TDenable) begin
                    state_d = StIdle;
                end else if (bus.i_ce) begin
                    take = 1'b1;
                end
            end
            StReport: begin
                if (!bus.TDenable) begin
                    state_d = StIdle;
                end else begin
`ifdef TD_CONFIRM_EN
                    prev_d  = cand;
                    match_d = new_match;
                    if (32'(new_match) >= CONFIRM_N) begin
                        tone_d  = cand;
                        done_d  = 1'b1;
                        state_d = StHold;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    tone_d  = cand;
                    done_d  = 1'b1;
                    state_d = StHold;
`endif
                end
            end
            StHold: begin
                if (!bus.TDenable) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            count_d    = cur_idx + CW'(1);
            peak_d     = better ? mag : base_peak;
            peak_idx_d = better ? cur_idx : base_idx;
            state_d    = (cur_idx == LAST_IDX) ? StReport : StScan;
        end

`ifdef TD_CONFIRM_EN
        if (!bus.TDenable) begin
            prev_d  = '0;
            match_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            peak_q     <= '0;
            peak_idx_q <= '0;
            done_q     <= 1'b0;
            tone_q     <= 16'h0000;
`ifdef TD_CONFIRM_EN
            prev_q     <= '0;
            match_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            peak_q     <= peak_d;
            peak_idx_q <= peak_idx_d;
            done_q     <= done_d;
            tone_q     <= tone_d;
`ifdef TD_CONFIRM_EN
            prev_q     <= prev_d;
            match_q    <= match_d;
`endif
        end
    end

    assign bus.done = done_q;
    assign bus.Tone = tone_q;

endmodule

// File: tb/tb_fft_tone_detector.sv
// Bench for fft_tone_detector: frame-level reference model (collects magnitudes of a frame,
// argmax at report time) checked every cycle, plus literal checks on directed frames.
module tb_fft_tone_detector;

    localparam int unsigned FFT_LEN   = 64;
    localparam int unsigned IW        = 8;
    localparam int unsigned MIN_BIN   = 1;
    localparam int unsigned THRESH    = 16;
    localparam int unsigned CONFIRM_N = 2;
    localparam int          HALF      = FFT_LEN / 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_tone_detector_if #(.IW(IW)) bus ();

    fft_tone_detector #(
        .FFT_LEN  (FFT_LEN),
        .IW       (IW),
        .MIN_BIN  (MIN_BIN),
        .THRESH   (THRESH),
        .CONFIRM_N(CONFIRM_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mag [0:HALF-1];
    int          m_n;
    bit          m_collect, m_pending, m_hold;
    logic        exp_done;
    logic [15:0] exp_tone;
    logic [15:0] m_prev;
    int          m_cnt;

    function automatic int mag_of(input logic [2*IW-1:0] r);
        int re, im;
        re = $signed(r[2*IW-1:IW]);
        im = $signed(r[IW-1:0]);
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction

    // Strongest bin of the collected half-frame, lowest index on ties.
    function automatic logic [15:0] best();
        int pk, ix;
        pk = 0;
        ix = 0;
        for (int i = MIN_BIN; i < HALF; i++) begin
            if (m_mag[i] > pk) begin
                pk = m_mag[i];
                ix = i;
            end
        end
        return (pk >= THRESH) ? 16'(ix) : 16'hFFFF;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_collect = 0; m_pending = 0; m_hold = 0; m_n = 0;
                exp_done = 1'b0; exp_tone = 16'h0000; m_prev = 16'h0; m_cnt = 0;
            end else begin
                if (m_hold) begin
                    if (!bus.TDenable) begin
                        m_hold   = 0;
                        exp_done = 1'b0;
                    end
                end else if (m_pending) begin
                    m_pending = 0;
                    if (bus.TDenable) begin
`ifdef TD_CONFIRM_EN
                        logic [15:0] c;
                        c = best();
                        m_cnt  = (m_cnt > 0 && c == m_prev) ? m_cnt + 1 : 1;
                        m_prev = c;
                        if (m_cnt >= CONFIRM_N) begin
                            exp_tone = c; exp_done = 1'b1; m_hold = 1;
                        end
`else
                        exp_tone = best(); exp_done = 1'b1; m_hold = 1;
`endif
                    end
                end else if (m_collect) begin
                    if (!bus.TDenable) begin
                        m_collect = 0;
                    end else if (bus.i_ce) begin
                        if (bus.o_sync) m_n = 0;
                        m_mag[m_n] = mag_of(bus.o_result);
                        if (m_n == HALF - 1) begin
                            m_collect = 0;
                            m_pending = 1;
                        end
                        m_n++;
                    end
                end else if (bus.TDenable && bus.i_ce && bus.o_sync) begin
                    m_mag[0]  = mag_of(bus.o_result);
                    m_n       = 1;
                    m_collect = 1;
                end
                if (!bus.TDenable) begin
                    m_prev = 16'h0;
                    m_cnt  = 0;
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("done_cycle", 32'(bus.done), 32'(exp_done));
                check("tone_cycle", 32'(bus.Tone), 32'(exp_tone));
            end
        end
    end

    // ---------------- stimulus ----------------
    int   fr_re [0:FFT_LEN-1];
    int   fr_im [0:FFT_LEN-1];
    logic en_v;
    int   done_bin;

    task automatic step(input logic ce, input logic sync, input int re, input int im);
        bus.TDenable = en_v;
        bus.i_ce     = ce;
        bus.o_sync   = sync;
        bus.o_result = {IW'(re), IW'(im)};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    // Plays bins lo..hi with `gap` ce-low garbage cycles before each sample; records the
    // first bin after whose edge done was seen high.
    task automatic play(input int lo, input int hi, input int gap);
        done_bin = -1;
        for (int b = lo; b <= hi; b++) begin
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)));
            step(1'b1, b == 0, fr_re[b], fr_im[b]);
            if (bus.done === 1'b1 && done_bin < 0) done_bin = b;
        end
    endtask

    task automatic clear_frame();
        for (int b = 0; b < FFT_LEN; b++) begin
            fr_re[b] = 0;
            fr_im[b] = 0;
        end
    endtask

    task automatic rand_frame(input int lim);
        for (int b = 0; b < FFT_LEN; b++) begin
            fr_re[b] = int'($urandom_range(0, 2 * lim)) - lim;
            fr_im[b] = int'($urandom_range(0, 2 * lim)) - lim;
        end
    endtask

    // Full frame with TDenable high, then TDenable low for two cycles.
    task automatic detect(input int gap);
        en_v = 1'b1;
        idle(1);
        play(0, FFT_LEN - 1, gap);
        en_v = 1'b0;
        idle(2);
    endtask

    initial begin
        reset = 1'b1;
        en_v  = 1'b0;
        bus.TDenable = 1'b0;
        bus.i_ce     = 1'b0;
        bus.o_sync   = 1'b0;
        bus.o_result = '0;
        idle(1);
        chk_en = 1'b1;
        idle(2);
        reset = 1'b0;
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_tone", 32'(bus.Tone), 32'h0);
        idle(2);

`ifdef TD_CONFIRM_EN
        en_v = 1'b1;
        idle(1);
        clear_frame(); fr_re[5] = 50;
        play(0, FFT_LEN - 1, 0);
        check("confirm_f1_nodone", 32'(done_bin), 32'hFFFF_FFFF);
        clear_frame(); fr_re[6] = 50;
        play(0, FFT_LEN - 1, 0);
        check("confirm_f2_nodone", 32'(done_bin), 32'hFFFF_FFFF);
        play(0, FFT_LEN - 1, 0);
        check("confirm_f3_latency", 32'(done_bin), 32'd32);
        check("confirm_tone", 32'(bus.Tone), 32'd6);
        check("confirm_model", 32'(exp_tone), 32'd6);
        en_v = 1'b0;
        idle(2);
`else
        // Single peak and report latency.
        clear_frame(); fr_re[5] = 40; fr_im[5] = -30;
        en_v = 1'b1;
        idle(1);
        play(0, FFT_LEN - 1, 0);
        check("single_latency", 32'(done_bin), 32'd32);
        check("single_tone", 32'(bus.Tone), 32'd5);
        check("single_model", 32'(exp_tone), 32'd5);
        en_v = 1'b0;
        idle(2);
        check("single_done_low", 32'(bus.done), 32'd0);
        check("single_tone_kept", 32'(bus.Tone), 32'd5);

        // Ties and the full-scale magnitude.
        clear_frame();
        fr_re[3] = 25; fr_im[3] = 25; fr_re[9] = 25; fr_im[9] = 25;
        fr_re[12] = -128; fr_im[12] = -128;
        detect(0);
        check("width_tone", 32'(bus.Tone), 32'd12);
        fr_re[12] = 0; fr_im[12] = 0;
        detect(0);
        check("tie_tone", 32'(bus.Tone), 32'd3);

        // Threshold and DC rejection: every non-DC bin has magnitude 10.
        for (int b = 0; b < FFT_LEN; b++) begin
            int r;
            r = int'($urandom_range(0, 10));
            fr_re[b] = $urandom_range(0, 1) ? r : -r;
            fr_im[b] = $urandom_range(0, 1) ? (10 - r) : (r - 10);
        end
        fr_re[0] = 127; fr_im[0] = 0;
        detect(0);
        check("thresh_none", 32'(bus.Tone), 32'hFFFF);
        check("thresh_model", 32'(exp_tone), 32'hFFFF);
        fr_re[7] = 20; fr_im[7] = 0;
        detect(0);
        check("thresh_bin7", 32'(bus.Tone), 32'd7);

        // Sparse i_ce, peak on the last scanned bin.
        rand_frame(40);
        fr_re[31] = 60; fr_im[31] = 60;
        detect(2);
        check("gap_tone", 32'(bus.Tone), 32'd31);

        // Resync at bin 10 discards the partial frame.
        clear_frame(); fr_re[4] = 100;
        en_v = 1'b1;
        idle(1);
        play(0, 9, 0);
        clear_frame(); fr_re[8] = 50;
        play(0, FFT_LEN - 1, 0);
        en_v = 1'b0;
        idle(2);
        check("resync_tone", 32'(bus.Tone), 32'd8);

        // Abort at bin 10.
        rand_frame(50); fr_re[6] = 127; fr_im[6] = 127;
        en_v = 1'b1;
        idle(1);
        play(0, 10, 0);
        en_v = 1'b0;
        play(11, FFT_LEN - 1, 0);
        check("abort_nodone", 32'(done_bin), 32'hFFFF_FFFF);
        check("abort_tone_kept", 32'(bus.Tone), 32'd8);

        // Reset mid-scan, then a normal detection.
        en_v = 1'b1;
        idle(1);
        play(0, 15, 0);
        reset = 1'b1;
        step(1'b1, 1'b0, 0, 0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_tone", 32'(bus.Tone), 32'h0);
        reset = 1'b0;
        clear_frame(); fr_re[20] = 90; fr_im[20] = -10;
        detect(0);
        check("after_reset_tone", 32'(bus.Tone), 32'd20);
`endif

        // Randomized frames: random content, gaps, aborts and resyncs against the model.
        for (int k = 0; k < 12; k++) begin
            int gap, cut;
            rand_frame(int'($urandom_range(1, 128)));
            if ($urandom_range(0, 1) == 1) begin
                fr_re[$urandom_range(0, HALF - 1)] = 127;
            end
            gap = int'($urandom_range(0, 2));
            cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : FFT_LEN - 1;
            en_v = 1'b1;
            idle(1);
            if ($urandom_range(0, 4) == 0) play(0, int'($urandom_range(1, 20)), gap);
            play(0, cut, gap);
            en_v = 1'b0;
            if (cut < FFT_LEN - 1) play(cut + 1, FFT_LEN - 1, gap);
            idle(2);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
